// File: rtl/bitplane_transposer.sv
// bitplane_transposer: splits up to NUM_WORDS words into prec bit-planes and writes them MSB-plane first to the MVU RAM.
// Define TRANSPOSER_DOUBLE_BUF_EN for ping-pong plane banks so a new job can fill while the previous one drains.
module bitplane_transposer #(
    parameter int unsigned NUM_WORDS     = 64,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MVU_ADDR_LEN  = 15,
    parameter int unsigned MVU_DATA_LEN  = 64,
    parameter int unsigned MAX_DATA_PREC = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [$clog2(MAX_DATA_PREC+1)-1:0] prec,
    input  logic [$clog2(NUM_WORDS+1)-1:0]     len,
    input  logic [MVU_ADDR_LEN-1:0]            baddr,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [XLEN-1:0]                    in_word,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic                               mvu_wr_en,
    output logic [MVU_ADDR_LEN-1:0]            mvu_wr_addr,
    output logic [MVU_DATA_LEN-1:0]            mvu_wr_word
);

    localparam int unsigned PW = $clog2(MAX_DATA_PREC+1);
    localparam int unsigned LW = $clog2(NUM_WORDS+1);
    localparam int unsigned CW = $clog2(NUM_WORDS);
    localparam int unsigned IW = $clog2(MAX_DATA_PREC);
`ifdef TRANSPOSER_DOUBLE_BUF_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif

    if (MVU_DATA_LEN != NUM_WORDS) begin : g_bad_width
        $error("bitplane_transposer: MVU_DATA_LEN must equal NUM_WORDS");
    end

    if (XLEN > MAX_DATA_PREC) begin : g_in_hi
        logic unused_in_hi;
        assign unused_in_hi = ^in_word[XLEN-1:MAX_DATA_PREC];
    end

    typedef enum logic [1:0] {F_IDLE, F_FILL, F_FULL} fill_state_t;
    typedef enum logic {D_IDLE, D_DRAIN} drain_state_t;

    fill_state_t  fill_st;
    drain_state_t drain_st;

    logic                     fill_bank, drain_bank;
    logic [LW-1:0]            job_len, cnt;
    logic [MAX_DATA_PREC-1:0] prec_mask;
    logic [NUM_WORDS-1:0]     planes     [NB][MAX_DATA_PREC];
    logic [PW-1:0]            bank_prec  [NB];
    logic [MVU_ADDR_LEN-1:0]  bank_baddr [NB];
    logic [PW-1:0]            dj;

    logic [PW-1:0]           d_prec;
    logic [IW-1:0]           d_top;
    logic [MVU_ADDR_LEN-1:0] d_addr;
    logic                    prec_ok, start_ok, drain_last, drain_free;

    assign d_prec     = bank_prec[drain_bank];
    assign d_top      = IW'(d_prec - PW'(1) - dj);
    assign d_addr     = bank_baddr[drain_bank] + MVU_ADDR_LEN'(dj);
    assign prec_ok    = (prec != '0) && (prec <= PW'(MAX_DATA_PREC));
    assign drain_last = (drain_st == D_DRAIN) && (dj == d_prec - PW'(1));
    // Accepting the hand-off on the last write lets a waiting bank drain with no idle cycle.
    assign drain_free = (drain_st == D_IDLE) || drain_last;
`ifdef TRANSPOSER_DOUBLE_BUF_EN
    assign start_ok   = 1'b1;
`else
    assign start_ok   = (drain_st == D_IDLE);
`endif

    assign in_ready = (fill_st == F_FILL);
    assign busy     = (fill_st != F_IDLE) || (drain_st != D_IDLE) || mvu_wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_st     <= F_IDLE;
            drain_st    <= D_IDLE;
            fill_bank   <= 1'b0;
            drain_bank  <= 1'b0;
            job_len     <= '0;
            cnt         <= '0;
            prec_mask   <= '0;
            dj          <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            mvu_wr_en   <= 1'b0;
            mvu_wr_addr <= '0;
            mvu_wr_word <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                bank_prec[i]  <= '0;
                bank_baddr[i] <= '0;
                for (int unsigned b = 0; b < MAX_DATA_PREC; b++) planes[i][b] <= '0;
            end
        end else begin
            err       <= 1'b0;
            done      <= 1'b0;
            mvu_wr_en <= 1'b0;

            if (drain_st == D_DRAIN) begin
                mvu_wr_en   <= 1'b1;
                mvu_wr_addr <= d_addr;
                mvu_wr_word <= planes[drain_bank][d_top];
                done        <= drain_last;
                if (drain_last) drain_st <= D_IDLE;
                else            dj       <= dj + PW'(1);
            end

            case (fill_st)
                F_IDLE: begin
                    if (start && start_ok) begin
                        if (!prec_ok) begin
                            err <= 1'b1;
                        end else begin
                            bank_prec[fill_bank]  <= prec;
                            bank_baddr[fill_bank] <= baddr;
                            job_len <= (len == '0) ? LW'(NUM_WORDS) : len;
                            cnt     <= '0;
                            for (int unsigned b = 0; b < MAX_DATA_PREC; b++) begin
                                prec_mask[b]         <= (PW'(b) < prec);
                                planes[fill_bank][b] <= '0;
                            end
                            fill_st <= F_FILL;
                        end
                    end
                end
                F_FILL: begin
                    if (in_valid) begin
                        for (int unsigned b = 0; b < MAX_DATA_PREC; b++)
                            planes[fill_bank][b][cnt[CW-1:0]] <= in_word[b] & prec_mask[b];
                        cnt <= cnt + LW'(1);
                        if (cnt == job_len - LW'(1)) fill_st <= F_FULL;
                    end
                end
                F_FULL: begin
                    if (drain_free) begin
                        fill_st    <= F_IDLE;
                        drain_st   <= D_DRAIN;
                        drain_bank <= fill_bank;
                        dj         <= '0;
`ifdef TRANSPOSER_DOUBLE_BUF_EN
                        fill_bank  <= ~fill_bank;
`endif
                    end
                end
                default: fill_st <= F_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitplane_transposer.sv
// Self-checking bench for bitplane_transposer: random and directed jobs against a plane-level reference model.
module tb_bitplane_transposer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  prec = '0;
    logic [6:0]  len = '0;
    logic [14:0] baddr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        busy, done, err, mvu_wr_en;
    logic [14:0] mvu_wr_addr;
    logic [63:0] mvu_wr_word;

    bitplane_transposer #(
        .NUM_WORDS(64), .XLEN(32), .MVU_ADDR_LEN(15), .MVU_DATA_LEN(64), .MAX_DATA_PREC(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .prec(prec), .len(len), .baddr(baddr),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .busy(busy), .done(done), .err(err),
        .mvu_wr_en(mvu_wr_en), .mvu_wr_addr(mvu_wr_addr), .mvu_wr_word(mvu_wr_word)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        check64(name, 64'(got), 64'(exp));
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        check64(name, 64'(got), 64'(exp));
    endtask

    typedef struct {
        logic [14:0] addr;
        logic [63:0] word;
        logic        last;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] log_word[$];
    logic [14:0] log_addr[$];
    int          log_cyc[$];
    logic [31:0] words[64];

    // Reference: write j carries plane p-1-j; bit k of that plane is bit (p-1-j) of word k, for k < effective len.
    task automatic model_job(input int p, input int l, input logic [14:0] a);
        int leff;
        wr_t e;
        leff = (l == 0) ? 64 : l;
        for (int j = 0; j < p; j++) begin
            e.word = '0;
            for (int k = 0; k < leff; k++) e.word[k] = words[k][p-1-j];
            e.addr = a + 15'(j);
            e.last = (j == p - 1);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst) begin
            if (mvu_wr_en) begin
                log_word.push_back(mvu_wr_word);
                log_addr.push_back(mvu_wr_addr);
                log_cyc.push_back(cyc);
                check1("busy_during_write", busy, 1'b1);
                if (exp_q.size() == 0) begin
                    check1("unexpected_write", mvu_wr_en, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check64("wr_addr", 64'(mvu_wr_addr), 64'(e.addr));
                    check64("wr_word", mvu_wr_word, e.word);
                    check1("wr_done", done, e.last);
                end
            end else if (done) begin
                check1("done_without_write", done, 1'b0);
            end
        end
    end

    task automatic clear_log();
        log_word.delete();
        log_addr.delete();
        log_cyc.delete();
    endtask

    task automatic start_job(input int p, input int l, input logic [14:0] a);
        model_job(p, l, a);
        start = 1'b1;
        prec  = 5'(p);
        len   = 7'(l);
        baddr = a;
        @(posedge clk); #1;
        start = 1'b0;
        check1("start_accepted_in_ready", in_ready, 1'b1);
        check1("start_accepted_busy", busy, 1'b1);
    endtask

    task automatic feed(input int l, input int gap_pct, output int hs_cyc);
        int leff;
        int t;
        leff = (l == 0) ? 64 : l;
        hs_cyc = cyc;
        for (int k = 0; k < leff; k++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_word  = $urandom;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_word  = words[k];
            t = 0;
            while (!in_ready && t < 300) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) begin
                check1("in_ready_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        hs_cyc   = cyc;
    endtask

    task automatic wait_first_write(input int h, input bit chk_lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!mvu_wr_en && t < 200) begin
            @(negedge clk);
            t++;
        end
        check1("first_write_seen", mvu_wr_en, 1'b1);
        if (chk_lat) check_int("first_write_latency", cyc, h + 2);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        check_int("job_queue_drained", exp_q.size(), 0);
        check1("idle_busy", busy, 1'b0);
        check1("idle_wr_en", mvu_wr_en, 1'b0);
    endtask

    task automatic run_job(input int p, input int l, input logic [14:0] a, input int gap_pct);
        int h;
        clear_log();
        start_job(p, l, a);
        feed(l, gap_pct, h);
        wait_first_write(h, 1'b1);
        wait_idle();
    endtask

    initial begin : main
        int h;
        int t;
        logic [4:0] bad_prec[2];

        #1 rst = 1'b1;
        #1;
        check1("reset_wr_en", mvu_wr_en, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        check1("reset_err", err, 1'b0);
        check1("reset_in_ready", in_ready, 1'b0);
        check64("reset_wr_word", mvu_wr_word, 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // prec=8, len=0 (64 words), word k = k
        for (int k = 0; k < 64; k++) words[k] = 32'(k);
        run_job(8, 0, 15'h100, 0);
        check_int("t1_write_count", log_word.size(), 8);
        if (log_word.size() == 8) begin
            check64("t1_plane7", log_word[0], 64'h0000000000000000);
            check64("t1_plane5", log_word[2], 64'hFFFFFFFF_00000000);
            check64("t1_plane4", log_word[3], 64'hFFFF0000_FFFF0000);
            check64("t1_plane0", log_word[7], 64'hAAAAAAAA_AAAAAAAA);
            check64("t1_addr_first", 64'(log_addr[0]), 64'h100);
            check64("t1_addr_last", 64'(log_addr[7]), 64'h107);
        end

        // prec=4, len=3, words 0xF,0x1,0x2 (junk above prec must be masked)
        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'h0000_0031;
        words[2] = 32'h1234_5672;
        run_job(4, 3, 15'h020, 0);
        check_int("t2_write_count", log_word.size(), 4);
        if (log_word.size() == 4) begin
            check64("t2_plane3", log_word[0], 64'h1);
            check64("t2_plane2", log_word[1], 64'h1);
            check64("t2_plane1", log_word[2], 64'h5);
            check64("t2_plane0", log_word[3], 64'h3);
        end

        // Illegal precision: err pulse, no job
        bad_prec[0] = 5'd0;
        bad_prec[1] = 5'd17;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            prec  = bad_prec[i];
            len   = 7'd4;
            @(posedge clk); #1;
            start = 1'b0;
            check1("t3_err_pulse", err, 1'b1);
            check1("t3_busy_low", busy, 1'b0);
            check1("t3_no_fill", in_ready, 1'b0);
            @(posedge clk); #1;
            check1("t3_err_one_cycle", err, 1'b0);
            check1("t3_busy_still_low", busy, 1'b0);
        end

        // Max precision, gaps, address wrap
        for (int k = 0; k < 64; k++) words[k] = $urandom;
        run_job(16, 0, 15'h7FFE, 40);
        check_int("t4_write_count", log_word.size(), 16);
        if (log_word.size() == 16) begin
            check64("t4_addr1", 64'(log_addr[1]), 64'h7FFF);
            check64("t4_addr_wrap", 64'(log_addr[2]), 64'h0000);
        end

        // Boundaries and random jobs
        for (int k = 0; k < 64; k++) words[k] = $urandom;
        run_job(1, 1, 15'h011, 0);
        run_job(16, 64, 15'h2A0, 10);
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 64; k++) words[k] = $urandom;
            run_job(int'($urandom_range(1, 16)), int'($urandom_range(0, 64)),
                    15'($urandom), int'($urandom_range(0, 50)));
        end

        // Second start while job 1 drains
        clear_log();
        for (int k = 0; k < 64; k++) words[k] = $urandom;
        start_job(16, 0, 15'h200);
        feed(0, 0, h);
        wait_first_write(h, 1'b1);
`ifdef TRANSPOSER_DOUBLE_BUF_EN
        for (int k = 0; k < 64; k++) words[k] = $urandom;
        start_job(4, 4, 15'h300);
        feed(4, 0, h);
        wait_idle();
        check_int("t5_write_count", log_word.size(), 20);
        if (log_word.size() == 20) begin
            check_int("t5_no_gap", log_cyc[16] - log_cyc[15], 1);
            check64("t5_job2_addr", 64'(log_addr[16]), 64'h300);
        end
`else
        start = 1'b1;
        prec  = 5'd4;
        len   = 7'd4;
        baddr = 15'h300;
        @(posedge clk); #1;
        start = 1'b0;
        check1("t5_no_err_on_ignored_start", err, 1'b0);
        t = 0;
        while (busy && t < 100) begin
            check1("t5_in_ready_during_drain", in_ready, 1'b0);
            @(posedge clk); #1;
            t++;
        end
        check1("t5_busy_done", busy, 1'b0);
        check1("t5_start_ignored", in_ready, 1'b0);
        wait_idle();
        check_int("t5_write_count", log_word.size(), 16);
`endif

        // Reset in the middle of a drain
        clear_log();
        for (int k = 0; k < 64; k++) words[k] = $urandom;
        start_job(16, 0, 15'h400);
        feed(0, 0, h);
        wait_first_write(h, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check1("t6_wr_en_cleared", mvu_wr_en, 1'b0);
        check1("t6_busy_cleared", busy, 1'b0);
        check1("t6_done_cleared", done, 1'b0);
        check1("t6_in_ready_cleared", in_ready, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check1("t6_idle_after_release", busy, 1'b0);
        for (int k = 0; k < 64; k++) words[k] = $urandom;
        run_job(5, 10, 15'h500, 20);
        check_int("t6_next_job_count", log_word.size(), 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL global_timeout: got time %0t required completion before it", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
